tcm_arbiter: RTL and testbench
==============================

Name: tcm_arbiter

Overview:
- Two-port arbiter and sequencer in front of one single-port sim_ram instance (ITCM or DTCM).
- Shares the RAM between requester m0 (e.g. IFU) and requester m1 (e.g. LSU).
- Converts byte addresses to word indices and issues at most one RAM command per cycle.
- Returns exactly one in-order response per accepted command, and holds the read data stable under response back-pressure.

Parameters:
DP, 512, RAM depth in words (must match the attached sim_ram)
DW, 32, data width
MW, 4, write-enable mask width (one bit per byte)
AW, 32, address width of requester and RAM address buses

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
m0_cmd_valid  input  1  m0 command valid
m0_cmd_ready  output  1  m0 command accepted this cycle when high with valid
m0_cmd_addr  input  AW  m0 byte address
m0_cmd_we  input  1  1=write, 0=read
m0_cmd_wem  input  MW  byte write mask
m0_cmd_wdata  input  DW  write data
m0_rsp_valid  output  1  m0 response valid
m0_rsp_ready  input  1  m0 response accepted
m0_rsp_rdata  output  DW  read data (0 for writes)
m0_rsp_err  output  1  access error
m1_*  same set as m0_*, for requester 1
ram_addr  output  AW  to sim_ram addr (word index)
ram_din  output  DW  to sim_ram din
ram_we  output  1  to sim_ram we
ram_wem  output  MW  to sim_ram wem
ram_dout  input  DW  from sim_ram dout

Behaviour:
- RAM model: a cycle with ram_we=0 latches ram_addr; ram_dout = mem[latched addr] combinationally. A cycle with ram_we=1 writes and keeps the latched address. Read latency is 1 cycle.
- Word index: ram_addr = {2'b00, cmd_addr[AW-1:2]}. cmd_addr[1:0] is ignored.
- State machine: IDLE, RSP0 (response owed to m0), RSP1 (response owed to m1).
- Issue window: state==IDLE, or the current response handshakes this cycle (rsp_valid & rsp_ready). No issue at any other time; both cmd_ready are 0.
- Grant: only one requester is valid -> grant it. Both valid -> grant the side selected by rr_ptr.
  - rr_ptr reset value is 0 (m0 has priority).
  - After a grant to mX, rr_ptr points to the other requester.
  - rr_ptr does not change when there is no grant.
- cmd_ready for the granted side = issue window. The other side's cmd_ready = 0. cmd_ready is combinational from valids, state and rsp_ready.
- On issue: drive ram_addr from the command, ram_we=cmd_we, ram_wem=cmd_wem (ram_we=0 forces effective mask off), ram_din=cmd_wdata. Next state is RSPx of the granted side.
- No issue: ram_we=0, ram_wem=0, ram_din=0. ram_addr = last_rd_idx register, which holds the word index of the most recent issued read.
  - This re-latches the same address, so ram_dout stays stable while a response is pending.
  - last_rd_idx is updated only on read issue; reset value 0.
- Response in RSPx:
  - mX_rsp_valid=1; the other side's rsp_valid=0.
  - rdata = ram_dout for a read, 0 for a write (captured op-type flag).
  - err=0.
- rsp_valid, rdata and err hold until rsp_ready.
- Back-to-back: a handshake plus a new grant in the same cycle -> RSPy directly, giving 1 command per cycle throughput. A handshake with no grant -> IDLE.
- Writes while a response is pending are impossible, because no issue occurs outside the window, so held read data cannot be corrupted.
- Reset values: every rsp_valid=0, rdata=0, err=0, cmd_ready=0 (state IDLE with no valids), ram_we=0, ram_wem=0, ram_din=0, ram_addr=0.
- Reset mid-operation: a pending response is dropped and the state returns to IDLE.

Optional Feature:
- Macro TCM_ARB_ADDR_CHK_EN.
- Defined:
  - A command with cmd_addr[AW-1:2] >= DP is still accepted normally.
  - Its RAM side is suppressed: ram_we=0, ram_addr=last_rd_idx.
  - Its response returns rdata=0 and err=1.
  - last_rd_idx is not updated for it.
- Undefined: no range check, err tied 0, address legality is the requester's responsibility.

Test Plan:
- m0 writes 0xDEADBEEF to addr 0x10 with wem=4'hF; m0 then reads 0x10 -> write rsp (rdata=0, err=0) one cycle after accept; read rsp rdata=0xDEADBEEF one cycle after accept; ram_addr=4.
- m0 and m1 both hold reads continuously from reset -> grants alternate m0, m1, m0, m1; one response per cycle with rsp_ready=1.
- m1 read of 0x20 with m1_rsp_ready=0 for 5 cycles while m0 requests a write to 0x20 -> m0_cmd_ready=0 throughout; ram_addr=8 each cycle; m1_rsp_rdata unchanged; write is accepted in the same cycle m1_rsp_ready rises.
- m0 byte write wem=4'b0010 with wdata=0x0000AB00 over a word holding 0x11223344, then read -> rdata=0x1122AB44.
- Assert rst_n low while in RSP1 -> m1_rsp_valid=0 immediately; after release the state is IDLE and rr_ptr=0 (m0 wins a tie).
- With TCM_ARB_ADDR_CHK_EN defined and DP=512: read of addr 0x800 -> err=1, rdata=0, ram_we=0. Without the macro: err=0.

Source files
------------

// File: rtl/tcm_arbiter_if.sv
// -----------------------------------------------------------------------------
// tcm_arbiter_if
// Requester-side command/response bundle for one port of tcm_arbiter.
//   cmd_valid / cmd_ready      : command handshake (requester -> arbiter)
//   cmd_addr                   : byte address
//   cmd_we / cmd_wem / cmd_wdata : write flag, byte mask, write data
//   rsp_valid / rsp_ready      : response handshake (arbiter -> requester)
//   rsp_rdata / rsp_err        : read data (0 for writes), access error
// Modports: master = requester view, slave = arbiter view.
// -----------------------------------------------------------------------------
interface tcm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_we;
    logic [MW-1:0] cmd_wem;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_we, cmd_wem, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_we, cmd_wem, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_arbiter
// Round-robin arbiter/sequencer sharing one single-port sim_ram between two
// requesters. At most one RAM command per cycle, one in-order response per
// accepted command, read data held stable while the response is back-pressured.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   m0, m1            : requester ports (tcm_arbiter_if.slave)
//   ram_addr          : word index to sim_ram
//   ram_din/we/wem    : write data, write enable, byte mask to sim_ram
//   ram_dout          : read data from sim_ram (1-cycle latency, latched addr)
//
// Optional feature (macro TCM_ARB_ADDR_CHK_EN): commands whose word index is
// >= DP are accepted, but never reach the RAM and respond with rdata=0, err=1.
// -----------------------------------------------------------------------------
module tcm_arbiter #(
    parameter int DP = 512,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    tcm_arbiter_if.slave  m0,
    tcm_arbiter_if.slave  m1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

`ifdef TCM_ARB_ADDR_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [AW-1:0] DP_IDX = AW'(DP);

    typedef enum logic [1:0] {IDLE, RSP0, RSP1} state_t;

    state_t        state_q;
    logic          rr_ptr_q;       // 0: m0 wins a tie, 1: m1 wins a tie
    logic [AW-1:0] last_rd_idx_q;  // word index of the most recent issued read
    logic          rsp_wr_q;       // pending response belongs to a write
    logic          rsp_err_q;      // pending response is an out-of-range access

    logic          hs0, hs1, win;
    logic          gnt0, gnt1, issue;
    logic [AW-1:0] sel_addr, sel_idx;
    logic          sel_we;
    logic [MW-1:0] sel_wem;
    logic [DW-1:0] sel_wdata;
    logic          oor;
    logic          ram_go;         // issued command actually touches the RAM

    always_comb begin
        hs0   = (state_q == RSP0) && m0.rsp_ready;
        hs1   = (state_q == RSP1) && m1.rsp_ready;
        // New commands only when nothing is owed or the owed response retires
        // this cycle, so a held read can never be disturbed.
        win   = (state_q == IDLE) || hs0 || hs1;
        gnt0  = win && m0.cmd_valid && (!m1.cmd_valid || !rr_ptr_q);
        gnt1  = win && m1.cmd_valid && (!m0.cmd_valid ||  rr_ptr_q);
        issue = gnt0 || gnt1;

        sel_addr  = gnt1 ? m1.cmd_addr  : m0.cmd_addr;
        sel_we    = gnt1 ? m1.cmd_we    : m0.cmd_we;
        sel_wem   = gnt1 ? m1.cmd_wem   : m0.cmd_wem;
        sel_wdata = gnt1 ? m1.cmd_wdata : m0.cmd_wdata;
        // Byte address to word index; the shift drops the byte-lane bits.
        sel_idx   = sel_addr >> 2;
        oor       = CHK_EN && (sel_idx >= DP_IDX);
        ram_go    = issue && !oor;

        m0.cmd_ready = gnt0;
        m1.cmd_ready = gnt1;

        // When idle or suppressed, re-present the last read index so the RAM
        // re-latches the same word and ram_dout stays put.
        ram_addr = ram_go ? sel_idx : last_rd_idx_q;
        ram_we   = ram_go && sel_we;
        ram_wem  = ram_we ? sel_wem : '0;
        ram_din  = ram_go ? sel_wdata : '0;

        m0.rsp_valid = (state_q == RSP0);
        m1.rsp_valid = (state_q == RSP1);
        m0.rsp_rdata = (m0.rsp_valid && !rsp_wr_q && !rsp_err_q) ? ram_dout : '0;
        m1.rsp_rdata = (m1.rsp_valid && !rsp_wr_q && !rsp_err_q) ? ram_dout : '0;
        m0.rsp_err   = m0.rsp_valid && rsp_err_q;
        m1.rsp_err   = m1.rsp_valid && rsp_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            last_rd_idx_q <= '0;
            rsp_wr_q      <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else if (issue) begin
            state_q   <= gnt1 ? RSP1 : RSP0;
            rr_ptr_q  <= gnt0;
            rsp_wr_q  <= sel_we;
            rsp_err_q <= oor;
            if (!sel_we && !oor) begin
                last_rd_idx_q <= sel_idx;
            end
        end else if (hs0 || hs1) begin
            state_q <= IDLE;
        end
    end

endmodule

// File: tb/tb_tcm_arbiter.sv
module tb_tcm_arbiter;
    localparam int DP = 512;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int AW = 32;
`ifdef TCM_ARB_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    tcm_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) m0_if ();
    tcm_arbiter_if #(.AW(AW), .DW(DW), .MW(MW)) m1_if ();

    tcm_arbiter #(.DP(DP), .DW(DW), .MW(MW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if.slave),
        .m1       (m1_if.slave),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sim_ram: reads latch the address, writes keep it.
    logic [DW-1:0] mem [0:DP-1];
    logic [AW-1:0] lat_q;
    initial begin
        for (int i = 0; i < DP; i++) mem[i] = '0;
        lat_q = '0;
    end
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < MW; b++)
                if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
        end else begin
            lat_q <= ram_addr;
        end
    end
    assign ram_dout = mem[lat_q[8:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [MW-1:0] wem, input logic [DW-1:0] wd);
        m0_if.cmd_valid = v; m0_if.cmd_we = we; m0_if.cmd_addr = a;
        m0_if.cmd_wem = wem; m0_if.cmd_wdata = wd;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a,
                          input logic [MW-1:0] wem, input logic [DW-1:0] wd);
        m1_if.cmd_valid = v; m1_if.cmd_we = we; m1_if.cmd_addr = a;
        m1_if.cmd_wem = wem; m1_if.cmd_wdata = wd;
    endtask

    task automatic apply_reset();
        drive0(0, 0, '0, '0, '0);
        drive1(0, 0, '0, '0, '0);
        m0_if.rsp_ready = 1'b1;
        m1_if.rsp_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m0_rsp_valid got %0b want 0", m0_if.rsp_valid); end
        n_checks++; if (m1_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m1_rsp_valid got %0b want 0", m1_if.rsp_valid); end
        n_checks++; if (m0_if.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m0_rdata got %h want 0", m0_if.rsp_rdata); end
        n_checks++; if (m1_if.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_m1_err got %0b want 0", m1_if.rsp_err); end
        n_checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 00", {m0_if.cmd_ready, m1_if.cmd_ready}); end
        n_checks++; if ({ram_we, ram_wem, ram_din, ram_addr} !== '0) begin n_fail++; $display("FAIL reset_ram_bus we=%0b wem=%h din=%h addr=%h want all 0", ram_we, ram_wem, ram_din, ram_addr); end
        $display("test_reset done");
    endtask

    task automatic test_write_read();
        drive0(1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
        #1;
        n_checks++; if (m0_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready got %0b want 1", m0_if.cmd_ready); end
        n_checks++; if ({ram_we, ram_wem, ram_addr, ram_din} !== {1'b1, 4'hF, 32'h4, 32'hDEADBEEF}) begin n_fail++; $display("FAIL wr_ram_bus we=%0b wem=%h addr=%h din=%h want 1 f 4 deadbeef", ram_we, ram_wem, ram_addr, ram_din); end
        step();
        n_checks++; if ({m0_if.rsp_valid, m0_if.rsp_rdata, m0_if.rsp_err} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL wr_rsp valid=%0b rdata=%h err=%0b want 1 0 0", m0_if.rsp_valid, m0_if.rsp_rdata, m0_if.rsp_err); end
        drive0(1, 0, 32'h10, 4'h0, 32'h0);
        #1;
        n_checks++; if ({m0_if.cmd_ready, ram_we, ram_addr} !== {1'b1, 1'b0, 32'h4}) begin n_fail++; $display("FAIL rd_issue ready=%0b we=%0b addr=%h want 1 0 4", m0_if.cmd_ready, ram_we, ram_addr); end
        step();
        n_checks++; if ({m0_if.rsp_valid, m0_if.rsp_rdata} !== {1'b1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL rd_rsp valid=%0b rdata=%h want 1 deadbeef", m0_if.rsp_valid, m0_if.rsp_rdata); end
        drive0(0, 0, '0, '0, '0);
        step();
        n_checks++; if (m0_if.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_drain rsp_valid got %0b want 0", m0_if.rsp_valid); end
        $display("test_write_read done");
    endtask

    task automatic test_round_robin();
        apply_reset();
        drive0(1, 0, 32'h10, '0, '0);
        drive1(1, 0, 32'h14, '0, '0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant_%0d got %b want %b", k, {m0_if.cmd_ready, m1_if.cmd_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            step();
            n_checks++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_rsp_%0d got %b want %b", k, {m0_if.rsp_valid, m1_if.rsp_valid}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            if (k % 2 == 0) begin
                n_checks++; if (m0_if.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rr_rdata_%0d got %h want deadbeef", k, m0_if.rsp_rdata); end
            end
        end
        drive0(0, 0, '0, '0, '0);
        drive1(0, 0, '0, '0, '0);
        step();
        $display("test_round_robin done");
    endtask

    task automatic test_back_pressure();
        apply_reset();
        drive1(1, 1, 32'h20, 4'hF, 32'hCAFE0001);
        #1;
        step();
        drive1(1, 0, 32'h20, '0, '0);
        #1;
        step();
        drive1(0, 0, '0, '0, '0);
        m1_if.rsp_ready = 1'b0;
        drive0(1, 1, 32'h20, 4'hF, 32'h55555555);
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if ({m0_if.cmd_ready, ram_we, ram_addr} !== {1'b0, 1'b0, 32'h8}) begin n_fail++; $display("FAIL bp_hold_%0d ready=%0b we=%0b addr=%h want 0 0 8", k, m0_if.cmd_ready, ram_we, ram_addr); end
            n_checks++; if ({m1_if.rsp_valid, m1_if.rsp_rdata} !== {1'b1, 32'hCAFE0001}) begin n_fail++; $display("FAIL bp_rsp_%0d valid=%0b rdata=%h want 1 cafe0001", k, m1_if.rsp_valid, m1_if.rsp_rdata); end
            step();
        end
        m1_if.rsp_ready = 1'b1;
        #1;
        n_checks++; if ({m0_if.cmd_ready, ram_we, ram_addr, m1_if.rsp_rdata} !== {1'b1, 1'b1, 32'h8, 32'hCAFE0001}) begin n_fail++; $display("FAIL bp_release ready=%0b we=%0b addr=%h rdata=%h want 1 1 8 cafe0001", m0_if.cmd_ready, ram_we, ram_addr, m1_if.rsp_rdata); end
        step();
        n_checks++; if ({m0_if.rsp_valid, m1_if.rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_after got %b want 10", {m0_if.rsp_valid, m1_if.rsp_valid}); end
        drive0(1, 0, 32'h20, '0, '0);
        #1;
        step();
        n_checks++; if (m0_if.rsp_rdata !== 32'h55555555) begin n_fail++; $display("FAIL bp_readback got %h want 55555555", m0_if.rsp_rdata); end
        drive0(0, 0, '0, '0, '0);
        step();
        $display("test_back_pressure done");
    endtask

    task automatic test_byte_write();
        drive0(1, 1, 32'h30, 4'hF, 32'h11223344);
        #1;
        step();
        drive0(1, 1, 32'h30, 4'b0010, 32'h0000AB00);
        #1;
        n_checks++; if ({ram_we, ram_wem, ram_addr} !== {1'b1, 4'b0010, 32'hC}) begin n_fail++; $display("FAIL bw_ram_bus we=%0b wem=%b addr=%h want 1 0010 c", ram_we, ram_wem, ram_addr); end
        step();
        drive0(1, 0, 32'h30, '0, '0);
        #1;
        step();
        n_checks++; if (m0_if.rsp_rdata !== 32'h1122AB44) begin n_fail++; $display("FAIL bw_readback got %h want 1122ab44", m0_if.rsp_rdata); end
        drive0(0, 0, '0, '0, '0);
        step();
        $display("test_byte_write done");
    endtask

    task automatic test_reset_mid_op();
        m1_if.rsp_ready = 1'b0;
        drive1(1, 0, 32'h20, '0, '0);
        #1;
        step();
        drive1(0, 0, '0, '0, '0);
        n_checks++; if (m1_if.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pending got %0b want 1", m1_if.rsp_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({m1_if.rsp_valid, m1_if.rsp_rdata, ram_addr} !== {1'b0, 32'h0, 32'h0}) begin n_fail++; $display("FAIL rst_mid_drop valid=%0b rdata=%h addr=%h want 0 0 0", m1_if.rsp_valid, m1_if.rsp_rdata, ram_addr); end
        drive0(1, 0, 32'h10, '0, '0);
        drive1(1, 0, 32'h14, '0, '0);
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if ({m0_if.cmd_ready, m1_if.cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_tie got %b want 10", {m0_if.cmd_ready, m1_if.cmd_ready}); end
        step();
        drive0(0, 0, '0, '0, '0);
        drive1(0, 0, '0, '0, '0);
        m1_if.rsp_ready = 1'b1;
        step();
        $display("test_reset_mid_op done");
    endtask

    task automatic test_addr_check();
        drive0(1, 0, 32'h800, '0, '0);
        #1;
        n_checks++; if ({m0_if.cmd_ready, ram_we} !== 2'b10) begin n_fail++; $display("FAIL ac_issue ready=%0b we=%0b want 1 0", m0_if.cmd_ready, ram_we); end
        n_checks++; if (ram_addr !== (CHK ? 32'h4 : 32'h200)) begin n_fail++; $display("FAIL ac_ram_addr got %h want %h", ram_addr, CHK ? 32'h4 : 32'h200); end
        step();
        n_checks++; if ({m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata} !== {1'b1, CHK, 32'h0}) begin n_fail++; $display("FAIL ac_rsp valid=%0b err=%0b rdata=%h want 1 %0b 0", m0_if.rsp_valid, m0_if.rsp_err, m0_if.rsp_rdata, CHK); end
        drive0(0, 0, '0, '0, '0);
        step();
        n_checks++; if (ram_addr !== (CHK ? 32'h4 : 32'h200)) begin n_fail++; $display("FAIL ac_last_idx got %h want %h", ram_addr, CHK ? 32'h4 : 32'h200); end
        $display("test_addr_check done");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_pressure();
        test_byte_write();
        test_reset_mid_op();
        test_addr_check();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
